comp_out_serializer: RTL
========================

Name: comp_out_serializer

Overview:
- Sits directly downstream of the LZRW1 compressor core.
- On the core's Done it captures the parallel result: the item byte array, the per-item control bits and the item count.
- Streams that result as an LZRW1 byte stream over a valid/ready byte interface.
- Each group of up to 16 items is preceded by a 16-bit control word, sent little-endian.

Parameters:
- STRINGSIZE, 350: depth of compArray in bytes and width of controlWord in bits. Matches the compressor.
- CNTW, $clog2(STRINGSIZE+1): width of item_count and out_count.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Done  in  1  compressor completion strobe; load request
- compArray  in  STRINGSIZE*8  compressed bytes, index 0 first; literal = 1 byte, copy = 2 bytes
- controlWord  in  STRINGSIZE  bit i = 1: item i is a copy; bit i = 0: item i is a literal
- item_count  in  CNTW  number of valid items
- busy  out  1  capture registers hold an unfinished job
- out_byte  out  8  stream byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts the byte
- out_last  out  1  final byte of the stream; qualified by out_valid
- out_done  out  1  one-cycle pulse when the job ends
- out_err  out  1  sticky overrun flag; cleared by the next accepted load
- out_count  out  CNTW  bytes emitted in the current or last job

Behaviour:
- Reset values: all outputs 0; state IDLE; capture registers 0.
- Load:
  - Done=1 in IDLE: capture compArray, controlWord and item_count; clear out_count and out_err; busy=1 the next cycle.
  - Done while busy is ignored.
- States: IDLE, CTRL_LO, CTRL_HI, ITEM_B0, ITEM_B1, FIN.
- Transitions:
  - IDLE -> CTRL_LO on load if item_count > 0.
  - IDLE -> FIN on load if item_count == 0. No bytes are emitted.
  - CTRL_LO -> CTRL_HI -> ITEM_B0.
  - ITEM_B0 -> ITEM_B1 if the current item is a copy.
  - ITEM_B0 or ITEM_B1 -> CTRL_LO when the item just finished completes a 16-item group and items remain.
  - ITEM_B0 or ITEM_B1 -> FIN when the last item is finished.
  - FIN -> IDLE after one cycle; out_done=1 and busy=0 in FIN.
- Control word for group g:
  - Bits = controlWord[16g+15:16g]; bits at item indices >= item_count are forced to 0.
  - CTRL_LO emits bits 7:0; CTRL_HI emits bits 15:8.
- Byte pointer:
  - Starts at 0 and advances 1 per accepted item byte.
  - out_byte = compArray[ptr] in the item states.
- Handshake:
  - out_valid=1 in CTRL_LO, CTRL_HI, ITEM_B0 and ITEM_B1.
  - A transfer occurs when out_valid && out_ready.
  - The state and pointer advance only on a transfer.
  - While out_valid=1 and out_ready=0, out_byte and out_last hold stable. No combinational path from out_ready to out_valid.
- out_count increments by 1 on every transfer and saturates at 2^CNTW-1.
- out_last=1 on the final item byte: the last byte of the last item.
- Overrun:
  - Condition: an item byte would read ptr >= STRINGSIZE.
  - Response: that byte is not emitted; out_err=1; go to FIN.
  - The preceding byte does not carry out_last.
- Reset in any state returns to IDLE next edge. out_valid=0 and the job is discarded.
- Done coincident with reset: reset wins.
- Throughput: 1 byte/cycle with out_ready held high. Done -> first out_valid latency is 1 cycle.

Optional Feature:
- Macro: COMP_SER_HEADER_EN.
- Defined:
  - Adds state HDR ahead of CTRL_LO.
  - HDR emits the 4-byte LZRW1 flag word FLAG_COMPRESS = 0x00000000, little-endian: 00 00 00 00.
  - These bytes count in out_count.
  - With item_count == 0, the header is still emitted and its fourth byte carries out_last.
- Undefined: the stream starts directly at CTRL_LO; no HDR state exists.

Test Plan:
- 3 literals AA BB CC, controlWord=0, item_count=3, out_ready=1:
  - Stream: 00 00 AA BB CC, out_last on CC.
  - out_count=5; out_done 1 cycle after CC.
- 1 copy + 1 literal, bytes 12 34 56, controlWord[1:0]=01, item_count=2:
  - Stream: 01 00 12 34 56.
  - controlWord[5]=1 (beyond item_count) still gives ctrl byte 01.
- 17 literals 00..10, controlWord=0:
  - Stream: 00 00, bytes 00..0F, then 00 00, then 10.
  - out_count=21.
- Same job as the first case, out_ready toggled 1,0,0,1,…:
  - out_byte stable during stalls; identical byte sequence.
  - Done pulsed mid-stream is ignored; busy stays 1.
- Overrun: STRINGSIZE=4, controlWord=0b1010, item_count=4, bytes 01 02 03 04:
  - Stream: 0A 00 01 02 03 04.
  - Item 3 would read ptr 4: out_err=1, no out_last, out_done pulses.
- Reset asserted during CTRL_HI → out_valid=0, busy=0 next cycle. A following load of item_count=0 gives out_done, no bytes; with COMP_SER_HEADER_EN it gives 00 00 00 00, out_last on the 4th byte.

Source files
------------

// File: rtl/comp_out_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : comp_out_serializer                                             |
// | Purpose  : Captures the parallel result of the LZRW1 compressor on Done    |
// |            and streams it as an LZRW1 byte stream over a valid/ready byte  |
// |            interface. Every group of up to 16 items is preceded by its     |
// |            16-bit control word, low byte first.                            |
// | Option   : COMP_SER_HEADER_EN - when defined, the stream is preceded by    |
// |            the 4-byte LZRW1 flag word FLAG_COMPRESS (00 00 00 00).         |
// | Ports    : clock, reset      - clock, synchronous active-high reset        |
// |            Done              - load request (ignored while busy)           |
// |            compArray         - item bytes, byte 0 in bits 7:0              |
// |            controlWord       - bit i set: item i is a 2-byte copy          |
// |            item_count        - number of valid items                       |
// |            busy              - an unfinished job is held                   |
// |            out_byte/valid/ready/last - byte stream handshake              |
// |            out_done          - one-cycle end-of-job pulse                  |
// |            out_err           - sticky overrun flag                         |
// |            out_count         - bytes emitted in the current/last job       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module comp_out_serializer #(
  parameter int STRINGSIZE = 350,
  parameter int CNTW       = $clog2(STRINGSIZE + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    Done,
  input  logic [STRINGSIZE*8-1:0] compArray,
  input  logic [STRINGSIZE-1:0]   controlWord,
  input  logic [CNTW-1:0]         item_count,
  output logic                    busy,
  output logic [7:0]              out_byte,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    out_done,
  output logic                    out_err,
  output logic [CNTW-1:0]         out_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CTRL_LO = 3'd1;
  localparam logic [2:0] S_CTRL_HI = 3'd2;
  localparam logic [2:0] S_ITEM_B0 = 3'd3;
  localparam logic [2:0] S_ITEM_B1 = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;
`ifdef COMP_SER_HEADER_EN
  localparam logic [2:0] S_HDR     = 3'd6;
`endif

  // Index widths wide enough to address the padded control window and
  // the bit position of any byte in the capture array.
  localparam int              PW   = $clog2(STRINGSIZE + 16);
  localparam int              AW   = $clog2(STRINGSIZE * 8);
  localparam logic [CNTW-1:0] C_SS = CNTW'(STRINGSIZE);

  logic [2:0]              r_state;
  logic [STRINGSIZE*8-1:0] r_arr;
  logic [STRINGSIZE-1:0]   r_ctl;
  logic [CNTW-1:0]         r_cnt;
  logic [CNTW-1:0]         r_ptr;        // next item byte to read
  logic [CNTW-1:0]         r_idx;        // current item index
  logic [3:0]              r_grp;        // item position inside its 16-item group
  logic [CNTW-1:0]         r_out_count;
  logic                    r_err;
`ifdef COMP_SER_HEADER_EN
  logic [1:0]              r_hdr_cnt;
`endif

  logic                    w_xfer;
  logic [STRINGSIZE+15:0]  w_ctl_pad;
  logic [PW-1:0]           w_win_idx;
  logic [15:0]             w_ctl_win;
  logic [15:0]             w_ctrl_word;
  logic                    w_is_copy;
  logic                    w_ptr_ok;
  logic [CNTW-1:0]         w_ptr_sel;
  logic [AW-1:0]           w_bit_idx;
  logic [7:0]              w_item_byte;
  logic [CNTW-1:0]         w_idx_nxt;
  logic [CNTW-1:0]         w_ptr_nxt;
  logic                    w_last_item;
  logic [2:0]              w_item_state;
  logic                    w_item_ovr;

  assign w_xfer = out_valid & out_ready;

  // 16-bit window of control bits starting at the current item. Zero
  // padding covers groups that run past the end of controlWord.
  assign w_ctl_pad = {16'b0, r_ctl};
  assign w_win_idx = PW'(r_idx);
  assign w_ctl_win = w_ctl_pad[w_win_idx +: 16];

  // Control bits of items at or beyond item_count are forced to zero.
  always_comb begin
    w_ctrl_word = '0;
    for (int k = 0; k < 16; k++) begin
      if ((w_win_idx + PW'(k)) < PW'(r_cnt)) begin
        w_ctrl_word[k] = w_ctl_win[k];
      end
    end
  end

  assign w_is_copy   = w_ctl_win[0];
  assign w_ptr_ok    = (r_ptr < C_SS);
  assign w_ptr_sel   = w_ptr_ok ? r_ptr : '0;
  assign w_bit_idx   = AW'(w_ptr_sel) << 3;
  assign w_item_byte = r_arr[w_bit_idx +: 8];
  assign w_idx_nxt   = r_idx + CNTW'(1);
  assign w_ptr_nxt   = r_ptr + CNTW'(1);
  assign w_last_item = (w_idx_nxt == r_cnt);

  // Where to go once the current item's final byte is accepted. The next
  // item's first byte is checked against the array end here so that an
  // overrunning byte is never presented.
  always_comb begin
    w_item_state = S_FIN;
    w_item_ovr   = 1'b0;
    if (w_last_item) begin
      w_item_state = S_FIN;
    end else if (r_grp == 4'd15) begin
      w_item_state = S_CTRL_LO;
    end else if (w_ptr_nxt < C_SS) begin
      w_item_state = S_ITEM_B0;
    end else begin
      w_item_state = S_FIN;
      w_item_ovr   = 1'b1;
    end
  end

  // Outputs decode registered state only, so they hold steady under stall
  // and have no path from out_ready.
  always_comb begin
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    case (r_state)
`ifdef COMP_SER_HEADER_EN
      S_HDR: begin
        out_valid = 1'b1;
        out_last  = (r_hdr_cnt == 2'd3) && (r_cnt == '0);
      end
`endif
      S_CTRL_LO: begin
        out_valid = 1'b1;
        out_byte  = w_ctrl_word[7:0];
      end
      S_CTRL_HI: begin
        out_valid = 1'b1;
        out_byte  = w_ctrl_word[15:8];
      end
      S_ITEM_B0: begin
        out_valid = 1'b1;
        out_byte  = w_item_byte;
        out_last  = w_last_item && !w_is_copy;
      end
      S_ITEM_B1: begin
        out_valid = 1'b1;
        out_byte  = w_item_byte;
        out_last  = w_last_item;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_FIN);
  assign out_done  = (r_state == S_FIN);
  assign out_err   = r_err;
  assign out_count = r_out_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_arr       <= '0;
      r_ctl       <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_grp       <= '0;
      r_out_count <= '0;
      r_err       <= 1'b0;
`ifdef COMP_SER_HEADER_EN
      r_hdr_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Done) begin
            r_arr       <= compArray;
            r_ctl       <= controlWord;
            r_cnt       <= item_count;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_grp       <= '0;
            r_out_count <= '0;
            r_err       <= 1'b0;
`ifdef COMP_SER_HEADER_EN
            r_hdr_cnt   <= '0;
            r_state     <= S_HDR;
`else
            r_state     <= (item_count != '0) ? S_CTRL_LO : S_FIN;
`endif
          end
        end
`ifdef COMP_SER_HEADER_EN
        S_HDR: begin
          if (w_xfer) begin
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            if (r_hdr_cnt == 2'd3) begin
              r_state <= (r_cnt != '0) ? S_CTRL_LO : S_FIN;
            end
          end
        end
`endif
        S_CTRL_LO: begin
          if (w_xfer) r_state <= S_CTRL_HI;
        end
        S_CTRL_HI: begin
          if (w_xfer) begin
            if (w_ptr_ok) begin
              r_state <= S_ITEM_B0;
            end else begin
              r_state <= S_FIN;
              r_err   <= 1'b1;
            end
          end
        end
        S_ITEM_B0: begin
          if (w_xfer) begin
            r_ptr <= w_ptr_nxt;
            if (w_is_copy) begin
              if (w_ptr_nxt < C_SS) begin
                r_state <= S_ITEM_B1;
              end else begin
                r_state <= S_FIN;
                r_err   <= 1'b1;
              end
            end else begin
              r_state <= w_item_state;
              r_idx   <= w_idx_nxt;
              r_grp   <= r_grp + 4'd1;  // wraps to 0 at each group start
              if (w_item_ovr) r_err <= 1'b1;
            end
          end
        end
        S_ITEM_B1: begin
          if (w_xfer) begin
            r_ptr   <= w_ptr_nxt;
            r_state <= w_item_state;
            r_idx   <= w_idx_nxt;
            r_grp   <= r_grp + 4'd1;
            if (w_item_ovr) r_err <= 1'b1;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_xfer && (r_out_count != '1)) begin
        r_out_count <= r_out_count + CNTW'(1);
      end
    end
  end

endmodule
`default_nettype wire
